// File: rtl/data_ram_rd_ctrl.sv
// data_ram_rd_ctrl: convolution-window read sequencer for data_ram.
// Build option RD_CTRL_PERF_EN adds a RUN-cycle stall counter.
module data_ram_rd_ctrl #(
    parameter int RAM_NUM  = 32,
    parameter int RAM_SIZE = 32,
    parameter int ADDR_DW  = 5,
    parameter int ROWS     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         cfg_kernel_dim,
    input  logic [1:0]         cfg_stride,
    input  logic [ADDR_DW-1:0] cfg_out_w,
    input  logic [3:0]         cfg_folds,
    input  logic               mem_sig,
    input  logic               stall,
    output logic [7:0]         addr_r_x,
    output logic [3:0]         addr_r_y,
    output logic [ADDR_DW-1:0] ram_select_r_x,
    output logic [ADDR_DW-1:0] ram_select_r_y,
    output logic [1:0]         STRIDE,
    output logic [3:0]         KERNEL_DIM,
    output logic               data_out_valid,
    output logic               dout_valid,
    output logic               dout_last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [15:0]        perf_stall_cnt
);

    if (RAM_NUM > (1 << ADDR_DW)) begin : g_bank_chk
        $error("RAM_NUM exceeds the bank select range");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_INIT,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    // latched configuration
    logic [3:0]         k_q, k_d;
    logic [1:0]         s_q, s_d;
    logic [ADDR_DW-1:0] ow_q, ow_d;
    logic [3:0]         nf_q, nf_d;

    // schedule counters
    logic [3:0]         kx_q, kx_d;
    logic [3:0]         ky_q, ky_d;
    logic [ADDR_DW-1:0] pos_q, pos_d;
    logic [3:0]         fold_q, fold_d;

    // registered read controls
    logic [7:0]         ax_q, ax_d;
    logic [3:0]         ay_q, ay_d;
    logic [ADDR_DW-1:0] rsx_q, rsx_d;
    logic [ADDR_DW-1:0] rsy_q, rsy_d;
    logic               dov_q, dov_d;
    logic               last_q, last_d;
    logic               dv_q, dv_d;
    logic               dl_q, dl_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [31:0]        cfg_need;
    logic               cfg_bad;
    logic               accept;
    logic               kx_last, ky_last, pos_last, fold_last;
    logic [ADDR_DW-1:0] rsx_w, rsy_w;

    // window must fit in the bank depth: (out_w-1)*S + K <= RAM_SIZE
    assign cfg_need = (32'(cfg_out_w) - 32'd1) * 32'(cfg_stride)
                    + 32'(cfg_kernel_dim);
    assign cfg_bad  = (cfg_stride == 2'd0)
                   || (cfg_kernel_dim == 4'd0)
                   || (cfg_out_w == '0)
                   || (cfg_folds == 4'd0)
                   || (cfg_need > 32'(RAM_SIZE));
    assign accept   = (state_q == IDLE) && start && !cfg_bad;

    assign kx_last   = (kx_q == k_q - 4'd1);
    assign ky_last   = (ky_q == k_q - 4'd1);
    assign pos_last  = (pos_q == ow_q - ADDR_DW'(1));
    assign fold_last = (fold_q == nf_q - 4'd1);

    // base addresses wrap to the select width
    assign rsx_w = ADDR_DW'(32'(fold_q) * 32'(ROWS) * 32'(s_q));
    assign rsy_w = ADDR_DW'(32'(pos_q) * 32'(s_q));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, schedule advance and read-control next values
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        s_d     = s_q;
        ow_d    = ow_q;
        nf_d    = nf_q;
        kx_d    = kx_q;
        ky_d    = ky_q;
        pos_d   = pos_q;
        fold_d  = fold_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        rsx_d   = rsx_q;
        rsy_d   = rsy_q;
        dov_d   = 1'b0;
        last_d  = 1'b0;
        dv_d    = dov_q;
        dl_d    = dov_q & last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && cfg_bad) begin
                    err_d = 1'b1;
                end else if (start) begin
                    k_d     = cfg_kernel_dim;
                    s_d     = cfg_stride;
                    ow_d    = cfg_out_w;
                    nf_d    = cfg_folds;
                    kx_d    = '0;
                    ky_d    = '0;
                    pos_d   = '0;
                    fold_d  = '0;
                    ax_d    = '0;
                    ay_d    = '0;
                    rsx_d   = '0;
                    rsy_d   = '0;
                    state_d = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (mem_sig) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    dov_d  = 1'b1;
                    last_d = kx_last && ky_last;
                    ax_d   = {4'd0, kx_q};
                    ay_d   = ky_q;
                    rsx_d  = rsx_w;
                    rsy_d  = rsy_w;
                    if (kx_last) begin
                        kx_d = '0;
                        if (ky_last) begin
                            ky_d = '0;
                            if (pos_last) begin
                                pos_d = '0;
                                if (fold_last) begin
                                    fold_d  = '0;
                                    state_d = DRAIN;
                                end else begin
                                    fold_d = fold_q + 4'd1;
                                end
                            end else begin
                                pos_d = pos_q + ADDR_DW'(1);
                            end
                        end else begin
                            ky_d = ky_q + 4'd1;
                        end
                    end else begin
                        kx_d = kx_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                ax_d    = '0;
                ay_d    = '0;
                rsx_d   = '0;
                rsy_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // configuration, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            s_q    <= '0;
            ow_q   <= '0;
            nf_q   <= '0;
            kx_q   <= '0;
            ky_q   <= '0;
            pos_q  <= '0;
            fold_q <= '0;
            ax_q   <= '0;
            ay_q   <= '0;
            rsx_q  <= '0;
            rsy_q  <= '0;
            dov_q  <= 1'b0;
            last_q <= 1'b0;
            dv_q   <= 1'b0;
            dl_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            k_q    <= k_d;
            s_q    <= s_d;
            ow_q   <= ow_d;
            nf_q   <= nf_d;
            kx_q   <= kx_d;
            ky_q   <= ky_d;
            pos_q  <= pos_d;
            fold_q <= fold_d;
            ax_q   <= ax_d;
            ay_q   <= ay_d;
            rsx_q  <= rsx_d;
            rsy_q  <= rsy_d;
            dov_q  <= dov_d;
            last_q <= last_d;
            dv_q   <= dv_d;
            dl_q   <= dl_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

`ifdef RD_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    // saturating count of stalled RUN cycles, cleared per job
    always_comb begin
        perf_d = perf_q;
        if (accept) begin
            perf_d = '0;
        end else if ((state_q == RUN) && stall && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    // stall counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    logic unused_accept;
    assign unused_accept  = accept;
    assign perf_stall_cnt = 16'h0000;
`endif

    assign addr_r_x       = ax_q;
    assign addr_r_y       = ay_q;
    assign ram_select_r_x = rsx_q;
    assign ram_select_r_y = rsy_q;
    assign STRIDE         = s_q;
    assign KERNEL_DIM     = k_q;
    assign data_out_valid = dov_q;
    assign dout_valid     = dv_q;
    assign dout_last      = dl_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign cfg_err        = err_q;

endmodule

// File: tb/tb_data_ram_rd_ctrl.sv
// tb_data_ram_rd_ctrl: directed bench for the data_ram read sequencer.
// Expected schedules come from a nested-loop window model.
module tb_data_ram_rd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  cfg_kernel_dim;
    logic [1:0]  cfg_stride;
    logic [4:0]  cfg_out_w;
    logic [3:0]  cfg_folds;
    logic        mem_sig;
    logic        stall;
    logic [7:0]  addr_r_x;
    logic [3:0]  addr_r_y;
    logic [4:0]  ram_select_r_x;
    logic [4:0]  ram_select_r_y;
    logic [1:0]  STRIDE;
    logic [3:0]  KERNEL_DIM;
    logic        data_out_valid;
    logic        dout_valid;
    logic        dout_last;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic [15:0] perf_stall_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [21:0] st[$];
    int          scy[$];
    bit          dl[$];
    int          dcy[$];
    int          dn[$];
    logic [21:0] exp_t[$];
    bit          exp_l[$];

    data_ram_rd_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cfg_kernel_dim (cfg_kernel_dim),
        .cfg_stride     (cfg_stride),
        .cfg_out_w      (cfg_out_w),
        .cfg_folds      (cfg_folds),
        .mem_sig        (mem_sig),
        .stall          (stall),
        .addr_r_x       (addr_r_x),
        .addr_r_y       (addr_r_y),
        .ram_select_r_x (ram_select_r_x),
        .ram_select_r_y (ram_select_r_y),
        .STRIDE         (STRIDE),
        .KERNEL_DIM     (KERNEL_DIM),
        .data_out_valid (data_out_valid),
        .dout_valid     (dout_valid),
        .dout_last      (dout_last),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_out_valid) begin
            st.push_back({addr_r_x, addr_r_y,
                          ram_select_r_x, ram_select_r_y});
            scy.push_back(cyc);
        end
        if (dout_valid) begin
            dl.push_back(dout_last);
            dcy.push_back(cyc);
        end
        if (done) dn.push_back(cyc);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_mon();
        st.delete();
        scy.delete();
        dl.delete();
        dcy.delete();
        dn.delete();
    endtask

    task automatic build_exp(input int k, input int s,
                             input int ow, input int f);
        exp_t.delete();
        exp_l.delete();
        for (int fo = 0; fo < f; fo++)
            for (int p = 0; p < ow; p++)
                for (int y = 0; y < k; y++)
                    for (int x = 0; x < k; x++) begin
                        logic [4:0] rx;
                        logic [4:0] ry;
                        rx = 5'((fo * 8 * s) % 32);
                        ry = 5'((p * s) % 32);
                        exp_t.push_back({8'(x), 4'(y), rx, ry});
                        exp_l.push_back((x == k - 1) && (y == k - 1));
                    end
    endtask

    task automatic do_start(input logic [3:0] k, input logic [1:0] s,
                            input logic [4:0] ow, input logic [3:0] f);
        @(posedge clk);
        #1;
        cfg_kernel_dim = k;
        cfg_stride     = s;
        cfg_out_w      = ow;
        cfg_folds      = f;
        start          = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (dn.size() == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (dn.size() == 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles",
                     budget);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({addr_r_x, addr_r_y, ram_select_r_x, ram_select_r_y,
             STRIDE, KERNEL_DIM, data_out_valid, dout_valid,
             dout_last, busy, done, cfg_err} !== '0) begin
            errors++;
            $display("FAIL rst_outputs: got nonzero outputs want 0");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: busy=%b dov=%b want 0 0",
                     busy, data_out_valid);
        end
        checks++;
        if (perf_stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_perf: got %h want 0000", perf_stall_cnt);
        end
    endtask

    task automatic test_basic();
        int ls;
        int fs;
        clear_mon();
        build_exp(3, 1, 2, 1);
        do_start(4'd3, 2'd1, 5'd2, 4'd1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_busy: got %b want 1", busy);
        end
        wait_done(100);
        checks++;
        if (st.size() != 18) begin
            errors++;
            $display("FAIL t1_count: got %0d want 18", st.size());
        end
        for (int i = 0; i < st.size() && i < exp_t.size(); i++) begin
            checks++;
            if (st[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL t1_tap[%0d]: got %h want %h",
                         i, st[i], exp_t[i]);
            end
        end
        checks++;
        if (dl.size() != 18) begin
            errors++;
            $display("FAIL t1_dout_count: got %0d want 18", dl.size());
        end
        for (int i = 0; i < dl.size() && i < exp_l.size(); i++) begin
            checks++;
            if (dl[i] !== exp_l[i] || dcy[i] != scy[i] + 1) begin
                errors++;
                $display("FAIL t1_dout[%0d]: last=%b cyc=%0d want %b %0d",
                         i, dl[i], dcy[i], exp_l[i], scy[i] + 1);
            end
        end
        ls = (scy.size() > 0) ? scy[scy.size() - 1] : -100;
        fs = (scy.size() > 0) ? scy[0] : -100;
        checks++;
        if (dn.size() != 1 || dn[0] != ls + 2) begin
            errors++;
            $display("FAIL t1_done: pulses=%0d want 1 at cyc %0d",
                     dn.size(), ls + 2);
        end
        checks++;
        if (ls - fs != 17) begin
            errors++;
            $display("FAIL t1_span: got %0d want 17", ls - fs);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL t1_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_stride_fold();
        clear_mon();
        build_exp(2, 2, 3, 2);
        do_start(4'd2, 2'd2, 5'd3, 4'd2);
        wait_done(100);
        checks++;
        if (st.size() != 24) begin
            errors++;
            $display("FAIL t2_count: got %0d want 24", st.size());
        end
        for (int i = 0; i < st.size() && i < exp_t.size(); i++) begin
            checks++;
            if (st[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL t2_tap[%0d]: got %h want %h",
                         i, st[i], exp_t[i]);
            end
        end
        checks++;
        if (st.size() < 24 || st[11][9:5] !== 5'd0 ||
            st[12][9:5] !== 5'd16 || st[8][4:0] !== 5'd4) begin
            errors++;
            $display("FAIL t2_bases: fold/pos base step wrong");
        end
        checks++;
        if (STRIDE !== 2'd2 || KERNEL_DIM !== 4'd2) begin
            errors++;
            $display("FAIL t2_cfg: S=%0d K=%0d want 2 2",
                     STRIDE, KERNEL_DIM);
        end
    endtask

    task automatic test_mem_wait();
        int c0;
        clear_mon();
        build_exp(3, 1, 2, 1);
        mem_sig = 1'b0;
        do_start(4'd3, 2'd1, 5'd2, 4'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b1 || st.size() != 0 ||
                data_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL t3_wait[%0d]: busy=%b strobes=%0d want 1 0",
                         i, busy, st.size());
            end
        end
        c0 = cyc;
        mem_sig = 1'b1;
        wait_done(100);
        checks++;
        if (scy.size() == 0 || scy[0] != c0 + 2) begin
            errors++;
            $display("FAIL t3_first: first strobe late, want cyc %0d",
                     c0 + 2);
        end
        checks++;
        if (st.size() != 18) begin
            errors++;
            $display("FAIL t3_count: got %0d want 18", st.size());
        end
        for (int i = 0; i < st.size() && i < exp_t.size(); i++) begin
            checks++;
            if (st[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL t3_tap[%0d]: got %h want %h",
                         i, st[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_stall();
        int n = 0;
        int ls;
        int fs;
        logic [15:0] exp_perf;
`ifdef RD_CTRL_PERF_EN
        exp_perf = 16'd4;
`else
        exp_perf = 16'd0;
`endif
        clear_mon();
        build_exp(3, 1, 2, 1);
        do_start(4'd3, 2'd1, 5'd2, 4'd1);
        while (st.size() < 4 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (data_out_valid !== 1'b0 || addr_r_x !== 8'd0 ||
                addr_r_y !== 4'd1) begin
                errors++;
                $display("FAIL t4_hold[%0d]: dov=%b x=%0d y=%0d want 0 0 1",
                         i, data_out_valid, addr_r_x, addr_r_y);
            end
        end
        stall = 1'b0;
        wait_done(100);
        checks++;
        if (st.size() != 18) begin
            errors++;
            $display("FAIL t4_count: got %0d want 18", st.size());
        end
        for (int i = 0; i < st.size() && i < exp_t.size(); i++) begin
            checks++;
            if (st[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL t4_tap[%0d]: got %h want %h",
                         i, st[i], exp_t[i]);
            end
        end
        for (int i = 0; i < dl.size() && i < exp_l.size(); i++) begin
            checks++;
            if (dl[i] !== exp_l[i] || dcy[i] != scy[i] + 1) begin
                errors++;
                $display("FAIL t4_dout[%0d]: last=%b want %b",
                         i, dl[i], exp_l[i]);
            end
        end
        ls = (scy.size() > 0) ? scy[scy.size() - 1] : -100;
        fs = (scy.size() > 0) ? scy[0] : -100;
        checks++;
        if (ls - fs != 21) begin
            errors++;
            $display("FAIL t4_span: got %0d want 21", ls - fs);
        end
        checks++;
        if (perf_stall_cnt !== exp_perf) begin
            errors++;
            $display("FAIL t4_perf: got %0d want %0d",
                     perf_stall_cnt, exp_perf);
        end
    endtask

    task automatic test_cfg_err();
        clear_mon();
        do_start(4'd3, 2'd0, 5'd2, 4'd1);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_s0: err=%b busy=%b want 1 0", cfg_err, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL t5_pulse: err=%b want 0", cfg_err);
        end
        do_start(4'd5, 2'd3, 5'd11, 4'd1);
        checks++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t5_ow11: err=%b busy=%b want 1 0",
                     cfg_err, busy);
        end
        build_exp(5, 3, 10, 1);
        do_start(4'd5, 2'd3, 5'd10, 4'd1);
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_ow10: err=%b busy=%b want 0 1",
                     cfg_err, busy);
        end
        do_start(4'd1, 2'd1, 5'd1, 4'd1);
        checks++;
        if (KERNEL_DIM !== 4'd5 || STRIDE !== 2'd3 || cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL t5_relatch: K=%0d S=%0d want 5 3",
                     KERNEL_DIM, STRIDE);
        end
        wait_done(400);
        checks++;
        if (st.size() != 250) begin
            errors++;
            $display("FAIL t5_count: got %0d want 250", st.size());
        end
        for (int i = 0; i < st.size() && i < exp_t.size(); i++) begin
            checks++;
            if (st[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL t5_tap[%0d]: got %h want %h",
                         i, st[i], exp_t[i]);
            end
        end
        checks++;
        if (perf_stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL t5_perf_clr: got %0d want 0", perf_stall_cnt);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        clear_mon();
        do_start(4'd3, 2'd1, 5'd2, 4'd1);
        while (st.size() < 5 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({addr_r_x, addr_r_y, ram_select_r_x, ram_select_r_y,
             STRIDE, KERNEL_DIM, data_out_valid, dout_valid,
             dout_last, busy, done, cfg_err} !== '0) begin
            errors++;
            $display("FAIL t6_async: outputs nonzero during reset");
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dn.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_nodone: done=%0d busy=%b want 0 0",
                     dn.size(), busy);
        end
        clear_mon();
        build_exp(3, 1, 2, 1);
        do_start(4'd3, 2'd1, 5'd2, 4'd1);
        wait_done(100);
        checks++;
        if (st.size() != 18) begin
            errors++;
            $display("FAIL t6_count: got %0d want 18", st.size());
        end
        for (int i = 0; i < st.size() && i < exp_t.size(); i++) begin
            checks++;
            if (st[i] !== exp_t[i]) begin
                errors++;
                $display("FAIL t6_tap[%0d]: got %h want %h",
                         i, st[i], exp_t[i]);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        start          = 1'b0;
        cfg_kernel_dim = '0;
        cfg_stride     = '0;
        cfg_out_w      = '0;
        cfg_folds      = '0;
        mem_sig        = 1'b1;
        stall          = 1'b0;
        test_reset();
        test_basic();
        test_stride_fold();
        test_mem_wait();
        test_stall();
        test_cfg_err();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_ram_rd_ctrl.md
Name: data_ram_rd_ctrl

Overview:
Read sequencer for the banked feature-map store (data_ram). It walks a convolution window schedule and drives its read controls: addr_r_x, addr_r_y, ram_select_r_x, ram_select_r_y, data_out_valid, STRIDE and KERNEL_DIM. The schedule is output-row fold → output position → kernel row → kernel column. It sits between the layer controller (start/config/done) and data_ram. It emits a valid/last strobe aligned with data_ram's one-cycle-late data_out for the systolic array.

Parameters:
RAM_NUM, 32, number of banks (x direction)
RAM_SIZE, 32, words per bank (y direction)
ADDR_DW, 5, bank select / word address width
ROWS, 8, output rows produced per fold (array rows)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches cfg_* when IDLE
cfg_kernel_dim  in  4  K, 1..15
cfg_stride  in  2  S, 1..3
cfg_out_w  in  ADDR_DW  output positions per fold along y, 1..RAM_SIZE
cfg_folds  in  4  number of x folds, 1..15
mem_sig  in  1  data_ram initialisation complete
stall  in  1  downstream hold
addr_r_x  out  8  kernel column offset kx
addr_r_y  out  4  kernel row offset ky
ram_select_r_x  out  ADDR_DW  fold base bank = fold*ROWS*S
ram_select_r_y  out  ADDR_DW  output position base = pos*S
STRIDE  out  2  latched S
KERNEL_DIM  out  4  latched K
data_out_valid  out  1  read strobe to data_ram
dout_valid  out  1  data_out_valid delayed 1 cycle (aligned with data_out)
dout_last  out  1  with dout_valid, last tap (kx=ky=K-1) of a window
busy  out  1  not IDLE
done  out  1  one-cycle pulse at completion
cfg_err  out  1  one-cycle pulse, rejected start
perf_stall_cnt  out  16  stall counter (see Optional Feature)

Behaviour:
- Reset state: all outputs 0; state IDLE; counters 0.
- Clock/reset: clk and rst_n are already decided. rst_n is asynchronous, active-low; clk is the only clock. Reset mid-operation aborts immediately, with no done pulse.
- States:
  - IDLE: on start, check the config.
    - Reject when cfg_stride=0, cfg_kernel_dim=0, cfg_out_w=0, cfg_folds=0, or (cfg_out_w-1)*S+K > RAM_SIZE. On reject: cfg_err=1 for 1 cycle, stay IDLE.
    - Otherwise latch STRIDE/KERNEL_DIM, clear counters, go to WAIT_INIT.
  - WAIT_INIT: go to RUN on the first cycle mem_sig=1. This can be the cycle after start.
  - RUN: each cycle with stall=0:
    - data_out_valid=1 and the counters advance: kx fastest, then ky, then pos, then fold.
    - Each counter wraps to 0 at its limit (K-1, K-1, cfg_out_w-1, cfg_folds-1).
    - Go to DRAIN after issuing the last tap (fold=folds-1, pos=out_w-1, ky=kx=K-1).
  - RUN with stall=1: data_out_valid=0 and all address outputs hold their values.
  - DRAIN: 1 cycle; the last dout_valid is emitted. Then go to DONE.
  - DONE: done=1 for 1 cycle, busy drops, go to IDLE.
- Address outputs in RUN:
  - addr_r_x=kx
  - addr_r_y=ky
  - ram_select_r_y=pos*S, truncated to ADDR_DW
  - ram_select_r_x=fold*ROWS*S, truncated to ADDR_DW
  - Address outputs are registered and change on the same edge data_out_valid asserts. They are 0 outside RUN.
- Pipeline alignment: dout_valid/dout_last are registered copies of data_out_valid and the last-tap flag. Latency is 1 cycle and stall does not affect it.
- Total issued strobes = cfg_folds*cfg_out_w*K*K, exactly, regardless of stall pattern.
- Edge cases:
  - start while busy is ignored; the config is not relatched.
  - stall in IDLE, WAIT_INIT or DONE has no effect.
  - mem_sig dropping during RUN is ignored.
  - K=1: every strobe has last=1.

Optional Feature:
- Macro: RD_CTRL_PERF_EN.
- Defined: perf_stall_cnt counts RUN cycles with stall=1. It saturates at 16'hFFFF, clears on an accepted start, and holds after done.
- Undefined: no counter logic is built and perf_stall_cnt is tied to 0.

Test Plan:
1. K=3, S=1, out_w=2, folds=1, mem_sig=1, no stall:
   - 18 strobes.
   - addr_r_x sequence 0,1,2 repeating; addr_r_y 0,0,0,1,1,1,2,2,2.
   - ram_select_r_y=0 for the first 9, then 1.
   - dout_last on strobes 9 and 18 (1 cycle late).
   - done 2 cycles after the last strobe.
2. K=2, S=2, out_w=3, folds=2:
   - ram_select_r_y steps 0,2,4.
   - ram_select_r_x is 0 for the first 12 strobes, then 16.
   - 24 strobes total.
3. Start with mem_sig=0 held for 5 cycles: busy=1, no strobes until mem_sig=1, then normal sequence of 1.
4. Stall: stall=1 for 4 cycles during the strobe with kx=1, ky=1 of case 1:
   - outputs hold and data_out_valid=0.
   - still exactly 18 strobes.
   - perf_stall_cnt=4 when RD_CTRL_PERF_EN is defined, 0 otherwise.
5. Config errors:
   - start with cfg_stride=0 → cfg_err pulse, busy stays 0.
   - start with K=5, S=3, out_w=10 → 27+5=32 ≤ 32 accepted; with out_w=11 → rejected.
6. rst_n asserted mid-RUN → all outputs 0 asynchronously, no done pulse; next start runs the full sequence.
